// File: rtl/pattern_pkg.sv
// Shared opcodes, run-length limits and controller states
// for the nucleotide pattern encoder.
package pattern_pkg;

    localparam int LEN_W = 4;
    localparam logic [LEN_W-1:0] LEN_MAX = 4'd15;

    localparam logic [7:0] OP_END   = 8'h00;
    localparam logic [7:0] OP_LIT   = 8'h10;
    localparam logic [7:0] OP_ANY   = 8'h20;
    localparam logic [7:0] OP_NEXT2 = 8'h21;
    localparam logic [7:0] OP_NEXT3 = 8'h22;
    localparam logic [7:0] OP_UPTO  = 8'h30;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        EMIT_CNT,
        EMIT_LIT,
        EMIT_END
    } state_t;

endpackage

// File: rtl/run_tracker.sv
// Holds the currently open run (nucleotide and length) and
// applies load, saturating increment and clear.
import pattern_pkg::*;

module run_tracker #(
    parameter int NW = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic             clear,
    input  logic [NW-1:0]    nuc,
    output logic [NW-1:0]    run_nuc,
    output logic [LEN_W-1:0] run_len,
    output logic             at_cap
);

    assign at_cap = (run_len == LEN_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            run_nuc <= '0;
            run_len <= '0;
        end else if (load) begin
            run_nuc <= nuc;
            run_len <= 4'd1;
        end else if (inc && !at_cap) begin
            run_len <= run_len + 4'd1;
        end else if (clear) begin
            run_len <= '0;
        end
    end

endmodule

// File: rtl/pattern_encoder.sv
// Run-length encoder: nucleotide stream in, count/literal/end
// pattern codes out, valid/ready on both sides.
import pattern_pkg::*;

module pattern_encoder #(
    parameter int NW = 2,
    parameter int PW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          nuc_valid,
    input  logic [NW-1:0] nuc,
    input  logic          nuc_last,
    output logic          nuc_ready,
    output logic          pat_valid,
    output logic [PW-1:0] pattern,
    input  logic          pat_ready
);

    state_t state, state_n;

    logic [NW-1:0]    emit_nuc, enuc_n;
    logic [LEN_W-1:0] emit_len, elen_n;
    logic             last_seen, last_n;
    logic [PW-1:0]    pat_n;
    logic             pv_n;

    logic             load, inc, clear;
    logic [NW-1:0]    run_nuc;
    logic [LEN_W-1:0] run_len;
    logic             at_cap;

    logic             close;
    logic [NW-1:0]    c_nuc;
    logic [LEN_W-1:0] c_len;

    logic accept, xfer;

    function automatic logic [PW-1:0] lit(input logic [NW-1:0] n);
        return PW'(OP_LIT) + PW'(n);
    endfunction

    assign nuc_ready = (state == IDLE) || (state == RUN);
    assign accept    = nuc_valid && nuc_ready;
    assign xfer      = pat_valid && pat_ready;

    run_tracker #(.NW(NW)) u_run (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .inc     (inc),
        .clear   (clear),
        .nuc     (nuc),
        .run_nuc (run_nuc),
        .run_len (run_len),
        .at_cap  (at_cap)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pat_valid <= 1'b0;
            pattern   <= PW'(OP_END);
            emit_nuc  <= '0;
            emit_len  <= '0;
            last_seen <= 1'b0;
        end else begin
            state     <= state_n;
            pat_valid <= pv_n;
            pattern   <= pat_n;
            emit_nuc  <= enuc_n;
            emit_len  <= elen_n;
            last_seen <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        pat_n   = pattern;
        pv_n    = pat_valid;
        enuc_n  = emit_nuc;
        elen_n  = emit_len;
        last_n  = last_seen;
        load    = 1'b0;
        inc     = 1'b0;
        clear   = 1'b0;
        close   = 1'b0;
        c_nuc   = run_nuc;
        c_len   = run_len;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (nuc_last) begin
                        last_n = 1'b1;
                        close  = 1'b1;
                        c_nuc  = nuc;
                        c_len  = 4'd1;
                    end else begin
                        load    = 1'b1;
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (nuc_last) last_n = 1'b1;
                    if (nuc == run_nuc && !at_cap) begin
                        // a last matching nucleotide closes the run in place
                        if (nuc_last) begin
                            close = 1'b1;
                            c_len = run_len + 4'd1;
                            clear = 1'b1;
                        end else begin
                            inc = 1'b1;
                        end
                    end else begin
                        close = 1'b1;
                        load  = 1'b1;
                    end
                end
            end
            EMIT_CNT: begin
                if (xfer) begin
                    state_n = EMIT_LIT;
                    pat_n   = lit(emit_nuc);
                end
            end
            EMIT_LIT: begin
                if (xfer) begin
                    if (last_seen && run_len != '0) begin
                        close = 1'b1;
                        clear = 1'b1;
                    end else if (last_seen) begin
                        state_n = EMIT_END;
                        pat_n   = PW'(OP_END);
                    end else begin
                        state_n = RUN;
                        pv_n    = 1'b0;
                    end
                end
            end
            EMIT_END: begin
                if (xfer) begin
                    last_n  = 1'b0;
                    state_n = IDLE;
                    pv_n    = 1'b0;
                    pat_n   = PW'(OP_END);
                end
            end
            default: state_n = IDLE;
        endcase

        if (close) begin
            enuc_n = c_nuc;
            elen_n = c_len;
            pv_n   = 1'b1;
            if (c_len != 4'd1) begin
                state_n = EMIT_CNT;
                pat_n   = PW'(c_len);
            end else begin
                state_n = EMIT_LIT;
                pat_n   = lit(c_nuc);
            end
        end
    end

endmodule

// File: tb/tb_pattern_encoder.sv
// Directed bench for pattern_encoder with a run-length model
// and a per-cycle output checker.
module tb_pattern_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       nuc_valid = 1'b0;
    logic [1:0] nuc = 2'd0;
    logic       nuc_last = 1'b0;
    logic       pat_ready = 1'b1;
    logic       nuc_ready;
    logic       pat_valid;
    logic [7:0] pattern;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] want[$];
    logic [1:0] stim[$];
    logic [7:0] e;
    logic [7:0] held_pat;
    bit         held = 0;
    bit         mon_en = 0;

    pattern_encoder #(.NW(2), .PW(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .nuc_valid (nuc_valid),
        .nuc       (nuc),
        .nuc_last  (nuc_last),
        .nuc_ready (nuc_ready),
        .pat_valid (pat_valid),
        .pattern   (pattern),
        .pat_ready (pat_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    // Output checker: every transfer pops the model queue
    always @(negedge clock) begin
        if (reset || !mon_en) begin
            held = 0;
        end else begin
            check("nuc_ready_vs_emit", {31'b0, nuc_ready}, {31'b0, !pat_valid});
            if (held) begin
                check("hold_valid", {31'b0, pat_valid}, 32'd1);
                check("hold_pattern", {24'b0, pattern}, {24'b0, held_pat});
            end
            if (pat_valid && pat_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_code: got %02h required none", pattern);
                end else begin
                    e = exp_q.pop_front();
                    check("code", {24'b0, pattern}, {24'b0, e});
                end
            end
            held = pat_valid && !pat_ready;
            held_pat = pattern;
        end
    end

    // Run-length model of the whole stimulus, pinned against want
    task automatic build_model();
        logic [7:0] m[$];
        int i = 0;
        int n = stim.size();
        while (i < n) begin
            int len = 1;
            logic [1:0] v = stim[i];
            while (i + len < n && stim[i+len] == v) len++;
            i += len;
            while (len > 0) begin
                int p = (len > 15) ? 15 : len;
                if (p >= 2) m.push_back(8'(p));
                m.push_back(8'h10 + {6'b0, v});
                len -= p;
            end
        end
        m.push_back(8'h00);
        check("model_size", m.size(), want.size());
        for (int k = 0; k < m.size() && k < want.size(); k++)
            check("model_code", {24'b0, m[k]}, {24'b0, want[k]});
        exp_q = m;
    endtask

    task automatic drive();
        for (int i = 0; i < stim.size(); i++) begin
            bit ok;
            int n = 0;
            nuc_valid = 1'b1;
            nuc = stim[i];
            nuc_last = (i == stim.size() - 1);
            do begin
                ok = nuc_ready;
                @(posedge clock);
                #1;
                n++;
            end while (!ok && n < 200);
            if (!ok) check("accept_timeout", 32'd0, 32'd1);
        end
        nuc_valid = 1'b0;
        nuc_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic fill(input logic [1:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) stim.push_back(v);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_pat_valid", {31'b0, pat_valid}, 32'd0);
        check("rst_pattern", {24'b0, pattern}, 32'h00);
        check("rst_nuc_ready", {31'b0, nuc_ready}, 32'd1);
        mon_en = 1;

        // single G with last
        stim = '{2'd2};
        want = '{8'h12, 8'h00};
        build_model();
        drive();
        drain();
        check("idle_ready", {31'b0, nuc_ready}, 32'd1);

        // A, C, G
        stim = '{2'd0, 2'd1, 2'd2};
        want = '{8'h10, 8'h11, 8'h12, 8'h00};
        build_model();
        drive();
        drain();

        // A x5
        stim.delete();
        fill(2'd0, 5);
        want = '{8'h05, 8'h10, 8'h00};
        build_model();
        drive();
        drain();

        // T x17 crosses the run cap
        stim.delete();
        fill(2'd3, 17);
        want = '{8'h0F, 8'h13, 8'h02, 8'h13, 8'h00};
        build_model();
        drive();
        drain();

        // G x3 then C, consumer stalls on 0x03
        stim.delete();
        fill(2'd2, 3);
        stim.push_back(2'd1);
        want = '{8'h03, 8'h12, 8'h11, 8'h00};
        build_model();
        pat_ready = 1'b0;
        fork
            drive();
            begin
                int n = 0;
                while (!pat_valid && n < 200) begin
                    @(posedge clock);
                    #1;
                    n++;
                end
                repeat (3) begin
                    check("stall_pattern", {24'b0, pattern}, 32'h03);
                    check("stall_nuc_ready", {31'b0, nuc_ready}, 32'd0);
                    @(posedge clock);
                    #1;
                end
                pat_ready = 1'b1;
            end
        join
        drain();

        // mixed runs under random backpressure
        stim = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
        want = '{8'h02, 8'h10, 8'h04, 8'h11, 8'h13, 8'h03, 8'h12, 8'h00};
        build_model();
        fork
            drive();
            begin
                int n = 0;
                while (exp_q.size() != 0 && n < 500) begin
                    @(posedge clock);
                    #1;
                    pat_ready = 1'($urandom_range(0, 1));
                    n++;
                end
                pat_ready = 1'b1;
            end
        join
        drain();

        // reset while 0x05 is presented
        stim.delete();
        fill(2'd0, 5);
        want = '{8'h05, 8'h10, 8'h00};
        build_model();
        pat_ready = 1'b0;
        drive();
        begin
            int n = 0;
            while (!pat_valid && n < 50) begin
                @(posedge clock);
                #1;
                n++;
            end
        end
        check("pre_reset_code", {24'b0, pattern}, 32'h05);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("post_reset_valid", {31'b0, pat_valid}, 32'd0);
        check("post_reset_ready", {31'b0, nuc_ready}, 32'd1);
        check("post_reset_pattern", {24'b0, pattern}, 32'h00);
        pat_ready = 1'b1;
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        check("post_reset_quiet", {31'b0, pat_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pattern_encoder.md
PATTERN_ENCODER -- requirements
Module: pattern_encoder

Interface
REQ-001 Parameter NW, default 2, SHALL set the nucleotide width (A=00, C=01, G=10, T=11).
REQ-002 Parameter PW, default 8, SHALL set the pattern-code width.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 nuc_valid  input  1  SHALL mark nuc and nuc_last as valid.
REQ-006 nuc  input  NW  SHALL carry the nucleotide.
REQ-007 nuc_last  input  1  SHALL mark the final nucleotide of a sequence.
REQ-008 nuc_ready  output  1  SHALL mark the encoder able to accept a nucleotide; a transfer occurs when nuc_valid and nuc_ready are both 1.
REQ-009 pat_valid  output  1  SHALL mark pattern as valid.
REQ-010 pattern  output  PW  SHALL carry the emitted pattern code.
REQ-011 pat_ready  input  1  SHALL mark the consumer able to accept; a transfer occurs when pat_valid and pat_ready are both 1.

Function
REQ-012 Input SHALL be run-length encoded into pattern codes: literal 0x10+nuc, count 0x0k (k=2..15), end 0x00.
REQ-013 A run of length 1 SHALL emit only the literal; a run of length k>=2 SHALL emit 0x0k, then the literal.
REQ-014 Runs SHALL be capped at 15; a matching nucleotide accepted while run_len==15 SHALL close the run and start a new run of length 1.
REQ-015 States SHALL be IDLE, RUN, EMIT_CNT, EMIT_LIT, EMIT_END.
REQ-016 nuc_ready SHALL be 1 in IDLE and RUN only, and 0 in every EMIT state.
REQ-017 IDLE + accept SHALL load run (nuc, len=1) and go to RUN; if nuc_last is set, the run SHALL close immediately.
REQ-018 RUN + accept of a matching nucleotide with len<15 SHALL increment len.
REQ-019 RUN + accept of a mismatching nucleotide, or the cap case, SHALL copy run to the emit registers, reload run with the new nucleotide at len 1, and go to EMIT_CNT (emit len>=2) or EMIT_LIT (emit len==1).
REQ-020 Accept with nuc_last SHALL set last_seen; the open run SHALL close after any pending emission.
REQ-021 After EMIT_LIT completes: if last_seen and a run is open, the encoder SHALL flush that run; if last_seen and no run is open, it SHALL go to EMIT_END; otherwise it SHALL go to RUN.
REQ-022 EMIT_END SHALL present 0x00; its transfer SHALL clear last_seen and return to IDLE.
REQ-023 pattern and pat_valid SHALL be registered, asserted in the cycle after the run-closing accept, and held stable while pat_ready is 0.
REQ-024 Each EMIT state SHALL advance only on an output transfer, with no idle cycle between consecutive codes when pat_ready stays 1.
REQ-025 Length arithmetic SHALL be 4-bit unsigned and never wrap.

Reset
REQ-026 Reset SHALL force IDLE, with pat_valid=0, pattern=0x00, run_len=0, last_seen=0; nuc_ready SHALL be 1 the cycle after reset deasserts.
REQ-027 Reset mid-emission SHALL discard all pending codes without completing the transfer.

Structure
REQ-028 Package pattern_pkg SHALL hold the opcode constants (OP_END 0x00, OP_LIT 0x10, OP_ANY 0x20, OP_NEXT2 0x21, OP_NEXT3 0x22, OP_UPTO 0x30) and the state enum.
REQ-029 One sub-module, run_tracker, SHALL hold run_nuc and run_len and implement the load, increment and cap logic.

Verification
REQ-030 A, C, G with last on G, pat_ready=1 -> 0x10, 0x11, 0x12, 0x00.
REQ-031 A x5 with last on the 5th -> 0x05, 0x10, 0x00.
REQ-032 T x17 with last on the 17th -> 0x0F, 0x13, 0x02, 0x13, 0x00.
REQ-033 G x3 then C with last, pat_ready=0 for 3 cycles while 0x03 is shown -> 0x03 held and nuc_ready=0 throughout, then 0x12, 0x11, 0x00.
REQ-034 Single G with last -> 0x12 then 0x00; the next input is accepted from IDLE.
REQ-035 Reset asserted while 0x05 is shown -> pat_valid=0 and nuc_ready=1 the next cycle, with no further codes.
